// File: rtl/axis_uart_tx_arbiter_if.sv
// Stream bundle for axis_uart_tx_arbiter: NUM_SRC byte sources in, one stream out to UART TX.
// slave is the arbiter's view; master is the surrounding sources + UART TX.
interface axis_uart_tx_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tlast;
    logic [NUM_SRC-1:0]        s_tready;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tvalid;
    logic                      m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid
    );
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX stream between NUM_SRC byte sources,
// with optional inter-packet idle gap and mid-packet stall release.
module axis_uart_tx_arbiter #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned GAP_CYCLES    = 0,
    parameter int unsigned STALL_TIMEOUT = 0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_uart_tx_arbiter_if.slave bus,
    output logic [NUM_SRC-1:0]    grant,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int unsigned SelW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [SelW-1:0] LastSrc = SelW'(NUM_SRC - 1);
    localparam logic [15:0]   GapLast  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0]   StallLim = 16'(STALL_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

    state_e             state_q, state_d;
    logic [SelW-1:0]    sel_q, sel_d;
    logic [SelW-1:0]    last_q, last_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [15:0]        gap_q, gap_d;
    logic [15:0]        stall_q, stall_d;
    logic               err_q, err_d;

    logic               pick_found;
    logic [SelW-1:0]    pick_idx;
    logic [SelW-1:0]    cand_idx;
    int unsigned        cand;
    logic [DATA_W-1:0]  tdata_sel;
    logic               tvalid_sel;
    logic               tlast_sel;
    logic               end_pkt;

    // Cyclic search starting one past the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            cand_idx = SelW'(cand);
            if (!pick_found && bus.s_tvalid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        tdata_sel  = '0;
        tvalid_sel = 1'b0;
        tlast_sel  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SelW'(i)) begin
                tdata_sel  = bus.s_tdata[i*DATA_W +: DATA_W];
                tvalid_sel = bus.s_tvalid[i];
                tlast_sel  = bus.s_tlast[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        grant_d      = grant_q;
        gap_d        = gap_q;
        stall_d      = stall_q;
        err_d        = 1'b0;
        end_pkt      = 1'b0;
        bus.m_tdata  = tdata_sel;
        bus.m_tvalid = 1'b0;
        bus.s_tready = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    sel_d            = pick_idx;
                    last_d           = pick_idx;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    stall_d          = '0;
                    state_d          = StXfer;
                end
            end
            StXfer: begin
                bus.m_tvalid = tvalid_sel;
                bus.s_tready = grant_q & {NUM_SRC{bus.m_tready}};
                if (tvalid_sel && bus.m_tready && tlast_sel) begin
                    end_pkt = 1'b1;
                end else if (STALL_TIMEOUT != 0) begin
                    // Only a missing source beat counts; UART backpressure never does.
                    if (tvalid_sel) begin
                        stall_d = '0;
                    end else if (stall_q + 16'd1 == StallLim) begin
                        end_pkt = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end
                if (end_pkt) begin
                    grant_d = '0;
                    stall_d = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES != 0) ? StGap : StIdle;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= LastSrc;
            grant_q <= '0;
            gap_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            gap_q   <= gap_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench for axis_uart_tx_arbiter: dut A (no gap, stall timeout 10) and
// dut B (5-cycle gap, no watchdog) driven from per-source beat memories.
module tb_axis_uart_tx_arbiter;
    localparam int unsigned NS = 4;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [NS-1:0] grant_a, grant_b;
    logic          busy_a, busy_b, err_a, err_b;

    axis_uart_tx_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus_a ();
    axis_uart_tx_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus_b ();

    axis_uart_tx_arbiter #(
        .NUM_SRC(NS), .DATA_W(DW), .GAP_CYCLES(0), .STALL_TIMEOUT(10)
    ) u_dut_a (
        .aclk(aclk), .aresetn(aresetn), .bus(bus_a),
        .grant(grant_a), .busy(busy_a), .err_timeout(err_a)
    );

    axis_uart_tx_arbiter #(
        .NUM_SRC(NS), .DATA_W(DW), .GAP_CYCLES(5), .STALL_TIMEOUT(0)
    ) u_dut_b (
        .aclk(aclk), .aresetn(aresetn), .bus(bus_b),
        .grant(grant_b), .busy(busy_b), .err_timeout(err_b)
    );

    always #5 aclk = ~aclk;

    exp_t          exp_a[$];
    exp_t          exp_b[$];
    logic [8:0]    mem [2][NS][32];
    int            rd_p [2][NS];
    int            wr_p [2][NS];
    logic [NS-1:0] acc [2];
    logic [NS-1:0] tv_drv [2];
    logic          rdy [2];
    logic          rst_v;
    logic          mv [2];
    logic          mr [2];
    logic [DW-1:0] md [2];
    logic [NS-1:0] gr [2];
    logic [NS-1:0] sr [2];
    logic          bz [2];
    logic          er [2];
    int            beats [2];
    int            cyc;
    int            n_vec;
    int            n_err;

    task automatic push_beat(input int d, input int s, input logic [7:0] data,
                             input logic last, input logic scored);
        exp_t e;
        mem[d][s][wr_p[d][s] % 32] = {last, data};
        wr_p[d][s]++;
        if (scored) begin
            e.src  = 2'(s);
            e.data = data;
            if (d == 0) exp_a.push_back(e);
            else        exp_b.push_back(e);
        end
    endtask

    // One clock: drive at posedge+1, sample and score at the following negedge.
    task automatic tick();
        logic [NS*DW-1:0] td;
        logic [NS-1:0]    tv, tl, oh;
        exp_t             e;
        logic             empty;
        @(posedge aclk);
        #1;
        aresetn = rst_v;
        for (int d = 0; d < 2; d++) begin
            td = '0; tv = '0; tl = '0;
            for (int s = 0; s < NS; s++) begin
                if (acc[d][s] && rd_p[d][s] < wr_p[d][s]) rd_p[d][s]++;
                if (rd_p[d][s] < wr_p[d][s]) begin
                    tv[s]          = 1'b1;
                    td[s*DW +: DW] = mem[d][s][rd_p[d][s] % 32][7:0];
                    tl[s]          = mem[d][s][rd_p[d][s] % 32][8];
                end
            end
            tv_drv[d] = tv;
            if (d == 0) begin
                bus_a.s_tdata = td; bus_a.s_tvalid = tv; bus_a.s_tlast = tl;
                bus_a.m_tready = rdy[0];
            end else begin
                bus_b.s_tdata = td; bus_b.s_tvalid = tv; bus_b.s_tlast = tl;
                bus_b.m_tready = rdy[1];
            end
        end
        @(negedge aclk);
        cyc++;
        mv[0] = bus_a.m_tvalid; mr[0] = bus_a.m_tready; md[0] = bus_a.m_tdata;
        gr[0] = grant_a; sr[0] = bus_a.s_tready; bz[0] = busy_a; er[0] = err_a;
        mv[1] = bus_b.m_tvalid; mr[1] = bus_b.m_tready; md[1] = bus_b.m_tdata;
        gr[1] = grant_b; sr[1] = bus_b.s_tready; bz[1] = busy_b; er[1] = err_b;
        for (int d = 0; d < 2; d++) begin
            acc[d] = tv_drv[d] & sr[d];
            if (mv[d] === 1'b1 && mr[d] === 1'b1) begin
                beats[d]++;
                n_vec++;
                empty = (d == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
                if (empty) begin
                    n_err++;
                    $display("FAIL sb_extra_beat dut%0d: got data %02h grant %b, required no beat",
                             d, md[d], gr[d]);
                end else begin
                    if (d == 0) e = exp_a.pop_front();
                    else        e = exp_b.pop_front();
                    oh = '0;
                    oh[e.src] = 1'b1;
                    if (md[d] !== e.data || gr[d] !== oh) begin
                        n_err++;
                        $display("FAIL sb_beat dut%0d: got data %02h grant %b, required data %02h grant %b",
                                 d, md[d], gr[d], e.data, oh);
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input int d, input int budget, input string name);
        int n = 0;
        while (((d == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0)) || bz[d] !== 1'b0) begin
            if (n >= budget) break;
            tick();
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL %s_drain dut%0d: still pending after %0d cycles, required idle", name, d, n);
        end
    endtask

    task automatic test_reset();
        rst_v = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_vec += 5;
            if (gr[d] !== '0) begin n_err++; $display("FAIL reset_grant dut%0d: got %b, required 0000", d, gr[d]); end
            if (bz[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d: got %b, required 0", d, bz[d]); end
            if (er[d] !== 1'b0) begin n_err++; $display("FAIL reset_err dut%0d: got %b, required 0", d, er[d]); end
            if (mv[d] !== 1'b0) begin n_err++; $display("FAIL reset_mvalid dut%0d: got %b, required 0", d, mv[d]); end
            if (sr[d] !== '0) begin n_err++; $display("FAIL reset_sready dut%0d: got %b, required 0000", d, sr[d]); end
        end
        rst_v = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] want;
        rdy[0] = 1'b1;
        push_beat(0, 0, 8'h41, 1'b0, 1'b1);
        push_beat(0, 0, 8'h42, 1'b0, 1'b1);
        push_beat(0, 0, 8'h43, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (gr[0] !== 4'b0000) begin n_err++; $display("FAIL single_arb_cycle: got grant %b, required 0000", gr[0]); end
        for (int k = 0; k < 3; k++) begin
            want = 8'h41 + 8'(k);
            tick();
            n_vec++;
            if (gr[0] !== 4'b0001 || mv[0] !== 1'b1 || md[0] !== want) begin
                n_err++;
                $display("FAIL single_beat%0d: got grant %b valid %b data %02h, required 0001 1 %02h",
                         k, gr[0], mv[0], md[0], want);
            end
        end
        tick();
        n_vec++;
        if (gr[0] !== 4'b0000 || bz[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: got grant %b busy %b, required 0000 0", gr[0], bz[0]);
        end
    endtask

    task automatic test_round_robin();
        int b0;
        b0 = beats[0];
        push_beat(0, 1, 8'h11, 1'b0, 1'b1);
        push_beat(0, 1, 8'h12, 1'b1, 1'b1);
        push_beat(0, 2, 8'h21, 1'b0, 1'b1);
        push_beat(0, 2, 8'h22, 1'b1, 1'b1);
        wait_done(0, 40, "rr_1_2");
        n_vec++;
        if (beats[0] - b0 != 4) begin n_err++; $display("FAIL rr_1_2_beats: got %0d, required 4", beats[0] - b0); end
        b0 = beats[0];
        push_beat(0, 1, 8'h13, 1'b0, 1'b0);
        push_beat(0, 1, 8'h14, 1'b1, 1'b0);
        push_beat(0, 3, 8'h31, 1'b1, 1'b1);
        push_beat(0, 1, 8'h13, 1'b0, 1'b1);
        push_beat(0, 1, 8'h14, 1'b1, 1'b1);
        rd_p[0][1] = rd_p[0][1] + 2; // drop the unscored duplicate so src1 carries one packet
        wait_done(0, 40, "rr_3_1");
        n_vec++;
        if (beats[0] - b0 != 3) begin n_err++; $display("FAIL rr_3_1_beats: got %0d, required 3", beats[0] - b0); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        logic [7:0] prev_d;
        logic       prev_stall;
        int         b0;
        int         k;
        pat = 4'b1001;
        prev_stall = 1'b0;
        prev_d = '0;
        b0 = beats[0];
        push_beat(0, 0, 8'h51, 1'b0, 1'b1);
        push_beat(0, 0, 8'h52, 1'b0, 1'b1);
        push_beat(0, 0, 8'h53, 1'b1, 1'b1);
        tick();
        k = 0;
        while ((exp_a.size() != 0 || bz[0] !== 1'b0) && k < 40) begin
            rdy[0] = pat[k % 4];
            tick();
            if (prev_stall) begin
                n_vec++;
                if (mv[0] !== 1'b1 || md[0] !== prev_d) begin
                    n_err++;
                    $display("FAIL bp_hold: got valid %b data %02h, required 1 %02h", mv[0], md[0], prev_d);
                end
            end
            prev_stall = (mv[0] === 1'b1) && (mr[0] === 1'b0);
            prev_d = md[0];
            k++;
        end
        rdy[0] = 1'b1;
        n_vec++;
        if (beats[0] - b0 != 3 || k >= 40) begin
            n_err++;
            $display("FAIL bp_beats: got %0d beats in %0d cycles, required 3", beats[0] - b0, k);
        end
    endtask

    task automatic test_gap();
        int b0, c0, c1, idle_n, busy_n;
        logic seen0;
        b0 = beats[1]; c0 = -1; c1 = -1; idle_n = 0; busy_n = 0; seen0 = 1'b0;
        rdy[1] = 1'b1;
        push_beat(1, 0, 8'h61, 1'b1, 1'b1);
        push_beat(1, 1, 8'h71, 1'b1, 1'b1);
        for (int k = 0; k < 40 && beats[1] - b0 < 2; k++) begin
            tick();
            if (beats[1] - b0 == 1 && !seen0) begin
                seen0 = 1'b1;
                c0 = cyc;
            end else if (beats[1] - b0 == 2) begin
                c1 = cyc;
            end else if (seen0) begin
                if (mv[1] === 1'b0) idle_n++;
                if (bz[1] === 1'b1) busy_n++;
            end
        end
        n_vec += 3;
        if (c1 - c0 != 7) begin n_err++; $display("FAIL gap_spacing: got %0d cycles, required 7", c1 - c0); end
        if (idle_n != 6) begin n_err++; $display("FAIL gap_idle: got %0d idle cycles, required 6", idle_n); end
        if (busy_n != 5) begin n_err++; $display("FAIL gap_busy: got %0d busy cycles, required 5", busy_n); end
        wait_done(1, 20, "gap");
    endtask

    task automatic test_stall();
        int bad;
        push_beat(0, 2, 8'h81, 1'b0, 1'b1);
        tick();
        tick();
        n_vec++;
        if (gr[0] !== 4'b0100 || md[0] !== 8'h81) begin
            n_err++; $display("FAIL stall_first: got grant %b data %02h, required 0100 81", gr[0], md[0]);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if (er[0] !== 1'b0 || gr[0] !== 4'b0100) begin
                n_err++; $display("FAIL stall_wait%0d: got err %b grant %b, required 0 0100", k, er[0], gr[0]);
            end
        end
        tick();
        n_vec++;
        if (er[0] !== 1'b1 || gr[0] !== 4'b0000) begin
            n_err++; $display("FAIL stall_fire: got err %b grant %b, required 1 0000", er[0], gr[0]);
        end
        tick();
        n_vec++;
        if (er[0] !== 1'b0) begin n_err++; $display("FAIL stall_pulse: got err %b, required 0", er[0]); end

        rdy[0] = 1'b0;
        push_beat(0, 3, 8'h91, 1'b0, 1'b1);
        push_beat(0, 3, 8'h92, 1'b1, 1'b1);
        tick();
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (er[0] !== 1'b0 || gr[0] !== 4'b1000) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL stall_backpressure: got %0d bad cycles, required 0", bad);
        end
        rdy[0] = 1'b1;
        wait_done(0, 20, "stall_bp");
    endtask

    task automatic test_reset_mid();
        push_beat(0, 0, 8'hA1, 1'b0, 1'b1);
        push_beat(0, 0, 8'hA2, 1'b0, 1'b0);
        push_beat(0, 0, 8'hA3, 1'b1, 1'b0);
        tick();
        tick();
        n_vec++;
        if (md[0] !== 8'hA1 || gr[0] !== 4'b0001) begin
            n_err++; $display("FAIL rstmid_first: got data %02h grant %b, required A1 0001", md[0], gr[0]);
        end
        rdy[0] = 1'b0;
        rst_v = 1'b0;
        for (int s = 0; s < NS; s++) rd_p[0][s] = wr_p[0][s];
        acc[0] = '0;
        push_beat(0, 0, 8'hB1, 1'b1, 1'b1);
        push_beat(0, 3, 8'hC1, 1'b1, 1'b1);
        tick();
        rst_v = 1'b1;
        tick();
        n_vec++;
        if (gr[0] !== 4'b0000 || mv[0] !== 1'b0 || sr[0] !== 4'b0000 || bz[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_state: got grant %b valid %b sready %b busy %b, required 0000 0 0000 0",
                     gr[0], mv[0], sr[0], bz[0]);
        end
        rdy[0] = 1'b1;
        tick();
        n_vec++;
        if (gr[0] !== 4'b0001) begin n_err++; $display("FAIL rstmid_prio: got grant %b, required 0001", gr[0]); end
        wait_done(0, 20, "rstmid");
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; rst_v = 1'b0;
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            acc[d] = '0; tv_drv[d] = '0; beats[d] = 0; bz[d] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                rd_p[d][s] = 0;
                wr_p[d][s] = 0;
            end
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_gap();
        test_stall();
        test_reset_mid();
        n_vec += 2;
        if (exp_a.size() != 0) begin n_err++; $display("FAIL sb_leftover dut0: got %0d pending, required 0", exp_a.size()); end
        if (exp_b.size() != 0) begin n_err++; $display("FAIL sb_leftover dut1: got %0d pending, required 0", exp_b.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, required completion");
        $fatal(1, "bench timeout");
    end
endmodule
